// File: rtl/semaforo_sequencer.sv
// semaforo_sequencer: upstream phase controller that times the traffic-light FSM through its change input.
// Optional pedestrian button path is compiled only when SEMAFORO_SEQ_PED_EN is defined.
module semaforo_sequencer #(
  parameter logic [15:0] GREEN_MIN   = 16'd20000,
  parameter logic [15:0] GREEN_MAX   = 16'd60000,
  parameter logic [15:0] RED_TIME    = 16'd40000,
  parameter logic [7:0]  DEB_LEN     = 8'd50,
  parameter logic [15:0] HANDOFF_MAX = 16'd40000
) (
  input  logic clklf,
  input  logic reset,
  input  logic en,
  input  logic ped_btn,
  input  logic green,
  input  logic yellow,
  input  logic red,
  output logic change,
  output logic ped_wait,
  output logic fault
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned DEB_W = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GREEN,
    S_RED,
    S_HANDOFF
  } state_t;

  typedef enum logic [2:0] {
    L_OFF,
    L_G,
    L_Y,
    L_R,
    L_ERR
  } light_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic             tgt_green_q, tgt_green_d;
  logic             change_q, change_d;
  logic             ped_wait_q, ped_wait_d;
  logic             fault_q, fault_d;
  logic             press_evt;
  light_t           light;

  // Decode light FSM outputs; unlisted codes are treated as an error
  always_comb begin
    case ({green, yellow, red})
      3'b100:  light = L_G;
      3'b010:  light = L_Y;
      3'b001:  light = L_R;
      3'b000:  light = L_OFF;
      default: light = L_ERR;
    endcase
  end

`ifdef SEMAFORO_SEQ_PED_EN
  logic [1:0]       sync_q, sync_d;
  logic [DEB_W-1:0] deb_q, deb_d;

  // Two-flop synchronizer and saturating debounce counter
  always_comb begin
    sync_d = {sync_q[0], ped_btn};
    deb_d  = '0;
    if (en && sync_q[1]) begin
      deb_d = (deb_q == DEB_LEN) ? deb_q : deb_q + DEB_W'(1);
    end
  end

  // Single-cycle event on the edge the count reaches DEB_LEN; saturation keeps a held button to one event
  assign press_evt = en && sync_q[1] && (deb_q == DEB_LEN - DEB_W'(1));

  always_ff @(posedge clklf) begin
    if (reset) begin
      sync_q <= '0;
      deb_q  <= '0;
    end else begin
      sync_q <= sync_d;
      deb_q  <= deb_d;
    end
  end
`else
  logic unused_ped_btn;
  assign unused_ped_btn = ped_btn;
  assign press_evt      = 1'b0;
`endif

  // Next-state, counters and registered outputs
  always_comb begin
    state_d     = state_q;
    dwell_d     = '0;
    hcnt_d      = '0;
    tgt_green_d = tgt_green_q;
    change_d    = 1'b0;
    ped_wait_d  = ped_wait_q;
    fault_d     = fault_q;

    if (!en) begin
      state_d    = S_IDLE;
      ped_wait_d = 1'b0;
    end else begin
      if (press_evt && (state_q != S_IDLE)) begin
        ped_wait_d = 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (!fault_q) begin
            if (light == L_G) begin
              state_d = S_GREEN;
            end else if (light == L_R) begin
              state_d = S_RED;
            end
          end
        end
        S_GREEN: begin
          if (light == L_ERR) begin
            fault_d = 1'b1;
            state_d = S_IDLE;
          end else if (light == L_OFF) begin
            state_d = S_IDLE;
          end else if ((dwell_q == GREEN_MAX - CNT_W'(1)) ||
                       ((ped_wait_q || press_evt) && (dwell_q >= GREEN_MIN - CNT_W'(1)))) begin
            change_d    = 1'b1;
            ped_wait_d  = 1'b0;
            tgt_green_d = 1'b0;
            state_d     = S_HANDOFF;
          end else begin
            dwell_d = dwell_q + CNT_W'(1);
          end
        end
        S_RED: begin
          if (light == L_ERR) begin
            fault_d = 1'b1;
            state_d = S_IDLE;
          end else if (light == L_OFF) begin
            state_d = S_IDLE;
          end else if (dwell_q == RED_TIME - CNT_W'(1)) begin
            change_d    = 1'b1;
            tgt_green_d = 1'b1;
            state_d     = S_HANDOFF;
          end else begin
            dwell_d = dwell_q + CNT_W'(1);
          end
        end
        S_HANDOFF: begin
          if (light == L_ERR) begin
            fault_d = 1'b1;
            state_d = S_IDLE;
          end else if (tgt_green_q && (light == L_G)) begin
            state_d = S_GREEN;
          end else if (!tgt_green_q && (light == L_R)) begin
            state_d = S_RED;
          end else if (hcnt_q == HANDOFF_MAX - CNT_W'(1)) begin
            fault_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            hcnt_d = hcnt_q + CNT_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clklf) begin
    if (reset) begin
      state_q     <= S_IDLE;
      dwell_q     <= '0;
      hcnt_q      <= '0;
      tgt_green_q <= 1'b0;
      change_q    <= 1'b0;
      ped_wait_q  <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      dwell_q     <= dwell_d;
      hcnt_q      <= hcnt_d;
      tgt_green_q <= tgt_green_d;
      change_q    <= change_d;
      ped_wait_q  <= ped_wait_d;
      fault_q     <= fault_d;
    end
  end

  assign change   = change_q;
  assign ped_wait = ped_wait_q;
  assign fault    = fault_q;

endmodule
